// File: rtl/ant_engine_if.sv
// Shared datapath handshake: the engine is the master, the memory/VGA datapath the slave.
interface ant_engine_if #(
   parameter int RES_W = 32,
   parameter int INS_W = 32
);
   logic             start_dp;
   logic [INS_W-1:0] instruction_dp;
   logic             finished_dp;
   logic [RES_W-1:0] result_dp;

   modport master (output start_dp, output instruction_dp, input finished_dp, input result_dp);
   modport slave  (input start_dp, input instruction_dp, output finished_dp, output result_dp);
endinterface

// File: rtl/ant_engine.sv
// Multi-ant engine: walks a table of ant records in memory, bouncing each ant off the
// screen walls, writing it back and drawing it, all through the shared datapath.
module ant_engine #(
   parameter int MAX_ANTS = 16,
   parameter int X_W      = 8,
   parameter int Y_W      = 7,
   parameter int V_W      = 4,
   parameter int MAX_X    = 156,
   parameter int MAX_Y    = 116,
   parameter int ADDR_W   = 16,
   parameter int RES_W    = 32,
   parameter int INS_W    = 32
) (
   input  logic                            clock,
   input  logic                            resetn,
   input  logic                            start,
   output logic                            finished,
   input  logic [ADDR_W-1:0]               base_address,
   input  logic [$clog2(MAX_ANTS+1)-1:0]   ant_count,
   input  logic [2:0]                      colour,
   input  logic                            erase_en,
   output logic [$clog2(MAX_ANTS)-1:0]     ant_index,
   ant_engine_if.master                    dp
);

   localparam int CW = $clog2(MAX_ANTS + 1);
   localparam logic signed [X_W+1:0] MAX_XS = (X_W+2)'(MAX_X);
   localparam logic signed [Y_W+1:0] MAX_YS = (Y_W+2)'(MAX_Y);
   localparam logic signed [V_W-1:0] V_MIN  = {1'b1, {(V_W-1){1'b0}}};
   localparam logic signed [V_W-1:0] V_MAX  = ~V_MIN;

   typedef enum logic [3:0] {
      S_IDLE, S_LD_X, S_LD_Y, S_LD_V, S_ERASE, S_MOVE,
      S_ST_X, S_ST_Y, S_ST_V, S_DRAW, S_NEXT
   } state_t;

   typedef enum logic [1:0] {P_ISSUE, P_HOLD, P_WAIT} phase_t;

   state_t                  state;
   phase_t                  phase;
   logic [ADDR_W-1:0]       rec_addr;
   logic [CW-1:0]           cnt;
   logic [CW-1:0]           cnt_clamped;
   logic [2:0]              col_r;
   logic                    erase_r;
   logic [X_W-1:0]          x_r;
   logic [Y_W-1:0]          y_r;
   logic signed [V_W-1:0]   dx_r;
   logic signed [V_W-1:0]   dy_r;

   logic signed [X_W+1:0]   sx;
   logic signed [Y_W+1:0]   sy;
   logic [X_W-1:0]          mv_x;
   logic [Y_W-1:0]          mv_y;
   logic signed [V_W-1:0]   mv_dx;
   logic signed [V_W-1:0]   mv_dy;

   logic [RES_W-1:0]        res;
   logic                    unused_res_hi;

   assign res           = dp.result_dp;
   assign unused_res_hi = ^res;

   function automatic logic signed [V_W-1:0] neg_sat(input logic signed [V_W-1:0] v);
      return (v == V_MIN) ? V_MAX : -v;
   endfunction

   function automatic logic [INS_W-1:0] ins_load(input logic [ADDR_W-1:0] a);
      logic [INS_W-1:0] w;
      w                = '0;
      w[INS_W-1 -: 4]  = 4'd2;
      w[ADDR_W-1:0]    = a;
      return w;
   endfunction

   function automatic logic [INS_W-1:0] ins_store(input logic [11:0] d, input logic [ADDR_W-1:0] a);
      logic [INS_W-1:0] w;
      w                = '0;
      w[INS_W-1 -: 4]  = 4'd3;
      w[ADDR_W +: 12]  = d;
      w[ADDR_W-1:0]    = a;
      return w;
   endfunction

   function automatic logic [INS_W-1:0] ins_draw(input logic [2:0] c, input logic [Y_W-1:0] y,
                                                  input logic [X_W-1:0] x);
      logic [INS_W-1:0] w;
      w                  = '0;
      w[INS_W-1 -: 4]    = 4'd1;
      w[X_W+Y_W+3]       = 1'b1;
      w[X_W+Y_W +: 3]    = c;
      w[X_W +: Y_W]      = y;
      w[X_W-1:0]         = x;
      return w;
   endfunction

   always_comb begin
      cnt_clamped = (ant_count > CW'(MAX_ANTS)) ? CW'(MAX_ANTS) : ant_count;
   end

   // Wall bounce: the sum is formed two bits wider so both underflow and overflow are visible.
   always_comb begin
      sx    = $signed({2'b00, x_r}) + (X_W+2)'(dx_r);
      sy    = $signed({2'b00, y_r}) + (Y_W+2)'(dy_r);
      mv_x  = sx[X_W-1:0];
      mv_dx = dx_r;
      mv_y  = sy[Y_W-1:0];
      mv_dy = dy_r;
      if (sx[X_W+1]) begin
         mv_x  = '0;
         mv_dx = neg_sat(dx_r);
      end else if (sx > MAX_XS) begin
         mv_x  = X_W'(MAX_X);
         mv_dx = neg_sat(dx_r);
      end
      if (sy[Y_W+1]) begin
         mv_y  = '0;
         mv_dy = neg_sat(dy_r);
      end else if (sy > MAX_YS) begin
         mv_y  = Y_W'(MAX_Y);
         mv_dy = neg_sat(dy_r);
      end
   end

   // Entering a transaction state raises start_dp and loads the instruction on the same
   // edge, so ISSUE and HOLD are the two cycles with start_dp high.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state             <= S_IDLE;
         phase             <= P_ISSUE;
         finished          <= 1'b1;
         dp.start_dp       <= 1'b0;
         dp.instruction_dp <= '0;
         ant_index         <= '0;
         rec_addr          <= '0;
         cnt               <= '0;
         col_r             <= '0;
         erase_r           <= 1'b0;
         x_r               <= '0;
         y_r               <= '0;
         dx_r              <= '0;
         dy_r              <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (!finished) begin
                  finished <= 1'b1;
               end else if (start) begin
                  finished <= 1'b0;
                  rec_addr <= base_address;
                  cnt      <= cnt_clamped;
                  col_r    <= colour;
                  erase_r  <= erase_en;
                  if (cnt_clamped != '0) begin
                     state             <= S_LD_X;
                     phase             <= P_ISSUE;
                     dp.start_dp       <= 1'b1;
                     dp.instruction_dp <= ins_load(base_address);
                  end
               end
            end

            S_MOVE: begin
               x_r               <= mv_x;
               y_r               <= mv_y;
               dx_r              <= mv_dx;
               dy_r              <= mv_dy;
               state             <= S_ST_X;
               phase             <= P_ISSUE;
               dp.start_dp       <= 1'b1;
               dp.instruction_dp <= ins_store(12'(mv_x), rec_addr);
            end

            S_NEXT: begin
               if (CW'(ant_index) == cnt - CW'(1)) begin
                  state     <= S_IDLE;
                  finished  <= 1'b1;
                  ant_index <= '0;
               end else begin
                  ant_index         <= ant_index + 1'b1;
                  rec_addr          <= rec_addr + ADDR_W'(4);
                  state             <= S_LD_X;
                  phase             <= P_ISSUE;
                  dp.start_dp       <= 1'b1;
                  dp.instruction_dp <= ins_load(rec_addr + ADDR_W'(4));
               end
            end

            default: begin
               case (phase)
                  P_ISSUE: phase <= P_HOLD;
                  P_HOLD: begin
                     phase       <= P_WAIT;
                     dp.start_dp <= 1'b0;
                  end
                  default: begin
                     if (dp.finished_dp) begin
                        phase <= P_ISSUE;
                        case (state)
                           S_LD_X: begin
                              x_r               <= res[X_W-1:0];
                              state             <= S_LD_Y;
                              dp.start_dp       <= 1'b1;
                              dp.instruction_dp <= ins_load(rec_addr + ADDR_W'(1));
                           end
                           S_LD_Y: begin
                              y_r               <= res[Y_W-1:0];
                              state             <= S_LD_V;
                              dp.start_dp       <= 1'b1;
                              dp.instruction_dp <= ins_load(rec_addr + ADDR_W'(2));
                           end
                           S_LD_V: begin
                              dx_r <= res[V_W-1:0];
                              dy_r <= res[2*V_W-1:V_W];
                              if (erase_r) begin
                                 state             <= S_ERASE;
                                 dp.start_dp       <= 1'b1;
                                 dp.instruction_dp <= ins_draw(3'b000, y_r, x_r);
                              end else begin
                                 state <= S_MOVE;
                              end
                           end
                           S_ERASE: state <= S_MOVE;
                           S_ST_X: begin
                              state             <= S_ST_Y;
                              dp.start_dp       <= 1'b1;
                              dp.instruction_dp <= ins_store(12'(y_r), rec_addr + ADDR_W'(1));
                           end
                           S_ST_Y: begin
                              state             <= S_ST_V;
                              dp.start_dp       <= 1'b1;
                              dp.instruction_dp <= ins_store(12'({dy_r, dx_r}), rec_addr + ADDR_W'(2));
                           end
                           S_ST_V: begin
                              state             <= S_DRAW;
                              dp.start_dp       <= 1'b1;
                              dp.instruction_dp <= ins_draw(col_r, y_r, x_r);
                           end
                           S_DRAW:  state <= S_NEXT;
                           default: state <= S_IDLE;
                        endcase
                     end
                  end
               endcase
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ant_engine.sv
// Bench for ant_engine: a memory/datapath responder, a record-level model of the ant walk,
// and a per-transaction compare against the model's expected instruction stream.
module tb_ant_engine;

   logic        clock = 1'b0;
   logic        resetn = 1'b0;
   logic        start = 1'b0;
   logic        finished;
   logic [15:0] base_address = '0;
   logic [4:0]  ant_count = '0;
   logic [2:0]  colour = '0;
   logic        erase_en = 1'b0;
   logic [3:0]  ant_index;

   ant_engine_if dp_bus ();

   ant_engine dut (
      .clock        (clock),
      .resetn       (resetn),
      .start        (start),
      .finished     (finished),
      .base_address (base_address),
      .ant_count    (ant_count),
      .colour       (colour),
      .erase_en     (erase_en),
      .ant_index    (ant_index),
      .dp           (dp_bus)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] ins;
      int          idx;
   } txn_t;

   txn_t        expq[$];
   txn_t        e;
   int          mem[int];
   int          mmem[int];
   int          checks = 0;
   int          errors = 0;
   int          n_txn = 0;
   int          dly = 0;
   bit          busy = 0;
   bit          in_wait = 0;
   int          hi = 0;
   int          wcnt = 0;
   logic [31:0] cur_ins;
   int          cur_a;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   function automatic logic [31:0] f_ld(input int a);
      return {4'd2, 12'd0, 16'(a)};
   endfunction
   function automatic logic [31:0] f_st(input int d, input int a);
      return {4'd3, 12'(d), 16'(a)};
   endfunction
   function automatic logic [31:0] f_dr(input int c, input int y, input int x);
      return {4'd1, 9'd0, 1'b1, 3'(c), 7'(y), 8'(x)};
   endfunction

   task automatic push(input logic [31:0] ins, input int idx);
      expq.push_back('{ins: ins, idx: idx});
   endtask

   task automatic bounce(input int p, input int v, input int mx, output int np, output int nv);
      int s;
      s  = p + v;
      np = s;
      nv = v;
      if (s < 0 || s > mx) begin
         np = (s < 0) ? 0 : mx;
         nv = (v == -8) ? 7 : -v;
      end
   endtask

   task automatic put_raw(input int a, input int wx, input int wy, input int wv);
      mem[a] = wx; mem[a+1] = wy; mem[a+2] = wv;
      mmem[a] = wx; mmem[a+1] = wy; mmem[a+2] = wv;
   endtask

   task automatic put_ant(input int a, input int x, input int y, input int dx, input int dy);
      put_raw(a, x, y, ((dy & 15) << 4) | (dx & 15));
   endtask

   // Record-level model: one pass over the table, producing the expected datapath stream.
   task automatic model_pass(input int base, input int cnt, input int col, input bit er);
      int n, a, x, y, dx, dy, nx, ny, ndx, ndy, w;
      n = (cnt > 16) ? 16 : cnt;
      for (int i = 0; i < n; i++) begin
         a  = base + 4 * i;
         x  = mmem[a] & 255;
         y  = mmem[a+1] & 127;
         dx = mmem[a+2] & 15;
         dy = (mmem[a+2] >> 4) & 15;
         if (dx >= 8) dx -= 16;
         if (dy >= 8) dy -= 16;
         push(f_ld(a), i); push(f_ld(a + 1), i); push(f_ld(a + 2), i);
         if (er) push(f_dr(0, y, x), i);
         bounce(x, dx, 156, nx, ndx);
         bounce(y, dy, 116, ny, ndy);
         w = ((ndy & 15) << 4) | (ndx & 15);
         mmem[a] = nx; mmem[a+1] = ny; mmem[a+2] = w;
         push(f_st(nx, a), i); push(f_st(ny, a + 1), i); push(f_st(w, a + 2), i);
         push(f_dr(col, ny, nx), i);
      end
   endtask

   task automatic cmp_mem(input int base, input int n);
      for (int i = 0; i < n; i++) begin
         for (int k = 0; k < 3; k++) begin
            chk("mem_record", mem[base + 4*i + k], mmem[base + 4*i + k]);
         end
      end
   endtask

   // Datapath responder; also the single compare point for every transaction.
   always @(negedge clock) begin
      if (!resetn) begin
         busy = 0;
         dp_bus.finished_dp = 1'b0;
      end else if (!busy) begin
         if (dp_bus.start_dp) begin
            cur_ins = dp_bus.instruction_dp;
            cur_a   = int'(cur_ins[15:0]);
            busy = 1; hi = 1; wcnt = 0; in_wait = 0;
            n_txn++;
            dp_bus.finished_dp = 1'b0;
            if (cur_ins[31:28] == 4'd2) dp_bus.result_dp = mem.exists(cur_a) ? mem[cur_a] : 0;
            else if (cur_ins[31:28] == 4'd3) mem[cur_a] = int'(cur_ins[27:16]);
            if (expq.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_txn: got %h, required none", cur_ins);
            end else begin
               e = expq.pop_front();
               chk("txn_ins", cur_ins, e.ins);
               chk("txn_ant_index", 32'(ant_index), 32'(e.idx));
            end
         end
      end else if (dp_bus.start_dp) begin
         hi++;
         if (dly < 0) dp_bus.finished_dp = 1'b1;
      end else begin
         if (!in_wait) begin
            in_wait = 1;
            chk("start_dp_cycles", hi, 2);
         end
         if (wcnt >= dly) begin
            dp_bus.finished_dp = 1'b1;
            busy = 0;
         end else begin
            wcnt++;
         end
      end
   end

   task automatic run_pass(input int base, input int cnt, input int col, input bit er,
                           input bit poke, output int ntx, output int cyc);
      int n0;
      n0 = n_txn;
      @(negedge clock);
      base_address = 16'(base); ant_count = 5'(cnt); colour = 3'(col); erase_en = er;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      chk("finished_low_after_start", finished, 0);
      cyc = 0;
      while (finished !== 1'b1 && cyc < 4000) begin
         @(negedge clock);
         cyc++;
         if (poke && cyc == 10) begin
            start = 1'b1; base_address = 16'hFFF0; ant_count = 5'd5;
            erase_en = ~er; colour = ~3'(col);
         end
         if (poke && cyc == 11) start = 1'b0;
      end
      start = 1'b0;
      chk("pass_done", finished, 1);
      chk("queue_drained", expq.size(), 0);
      ntx = n_txn - n0;
   endtask

   initial begin
      int ntx, cyc, nx, nv, n0, k;
      logic [31:0] lit [8];
      dp_bus.finished_dp = 1'b0;
      dp_bus.result_dp   = '0;

      #12;
      chk("reset_finished", finished, 1);
      chk("reset_start_dp", dp_bus.start_dp, 0);
      chk("reset_instruction", dp_bus.instruction_dp, 0);
      chk("reset_ant_index", ant_index, 0);
      @(negedge clock);
      resetn = 1'b1;

      // Pin the model's bounce rule with hand-worked cases.
      bounce(155, 3, 156, nx, nv);  chk("pin_x_hi", nx, 156);  chk("pin_dx_hi", nv, -3);
      bounce(1, -4, 116, nx, nv);   chk("pin_y_lo", nx, 0);    chk("pin_dy_lo", nv, 4);
      bounce(3, -8, 156, nx, nv);   chk("pin_x_sat", nx, 0);   chk("pin_dx_sat", nv, 7);

      // Single ant with erase.
      put_ant(32'h100, 10, 20, 3, -2);
      model_pass(32'h100, 1, 5, 1);
      lit[0] = 32'h2000_0100; lit[1] = 32'h2000_0101; lit[2] = 32'h2000_0102;
      lit[3] = 32'h1004_140A; lit[4] = 32'h300D_0100; lit[5] = 32'h3012_0101;
      lit[6] = 32'h30E3_0102; lit[7] = 32'h1006_920D;
      chk("pin_seq_len", expq.size(), 8);
      for (int j = 0; j < 8; j++) chk("pin_seq", expq[j].ins, lit[j]);
      dly = 0;
      run_pass(32'h100, 1, 5, 1, 0, ntx, cyc);
      chk("single_txns", ntx, 8);
      chk("single_x", mem[32'h100], 13);
      chk("single_y", mem[32'h101], 18);
      chk("single_v", mem[32'h102], 32'hE3);

      // Wall bounce, including saturated negation.
      put_ant(32'h180, 155, 1, 3, -4);
      put_ant(32'h184, 3, 115, -8, 7);
      model_pass(32'h180, 2, 2, 1);
      run_pass(32'h180, 2, 2, 1, 0, ntx, cyc);
      chk("bounce_x0", mem[32'h180], 156);
      chk("bounce_y0", mem[32'h181], 0);
      chk("bounce_v0", mem[32'h182], 32'h4D);
      chk("bounce_x1", mem[32'h184], 0);
      chk("bounce_y1", mem[32'h185], 116);
      chk("bounce_v1", mem[32'h186], 32'h97);

      // Three ants, no erase, slow datapath and a start pulse while busy.
      put_ant(32'h200, 40, 50, 1, 1);
      put_ant(32'h204, 0, 0, -1, -1);
      put_ant(32'h208, 156, 116, 7, 7);
      model_pass(32'h200, 3, 6, 0);
      dly = 7;
      run_pass(32'h200, 3, 6, 0, 1, ntx, cyc);
      chk("multi_txns", ntx, 21);
      cmp_mem(32'h200, 3);

      // Same shape with finished_dp raised early (already high on entering WAIT).
      put_ant(32'h280, 100, 60, -5, 3);
      put_ant(32'h284, 150, 112, 6, 4);
      put_ant(32'h288, 2, 2, -2, -3);
      model_pass(32'h280, 3, 7, 1);
      dly = -1;
      run_pass(32'h280, 3, 7, 1, 1, ntx, cyc);
      chk("early_txns", ntx, 24);
      cmp_mem(32'h280, 3);

      // Zero-length pass.
      dly = 0;
      run_pass(32'h500, 0, 1, 1, 0, ntx, cyc);
      chk("zero_txns", ntx, 0);
      chk("zero_busy_cycles", cyc, 1);

      // Over-range count clamps to the table size; high garbage bits are ignored on load.
      for (int i = 0; i < 21; i++) begin
         put_ant(32'h300 + 4*i, $urandom_range(156), $urandom_range(116),
                 int'($urandom_range(15)) - 8, int'($urandom_range(15)) - 8);
      end
      put_raw(32'h300, 32'hABCD_0012, 32'h7700_0045, 32'hFF00_0081);
      model_pass(32'h300, 21, 3, 0);
      dly = 1;
      run_pass(32'h300, 21, 3, 0, 0, ntx, cyc);
      chk("clamp_txns", ntx, 112);
      cmp_mem(32'h300, 16);
      chk("clamp_untouched", mem[32'h340], mmem[32'h340]);

      // Asynchronous reset in the WAIT phase of the second load.
      put_ant(32'h400, 20, 20, 1, 1);
      model_pass(32'h400, 1, 4, 1);
      dly = 50;
      n0 = n_txn;
      @(negedge clock);
      base_address = 16'h0400; ant_count = 5'd1; erase_en = 1'b1; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      k = 0;
      while (!(n_txn >= n0 + 2 && dp_bus.start_dp === 1'b0) && k < 300) begin
         @(negedge clock);
         k++;
      end
      chk("reached_ld_y_wait", dp_bus.instruction_dp, 32'h2000_0401);
      #2 resetn = 1'b0;
      #1;
      chk("async_reset_finished", finished, 1);
      chk("async_reset_start_dp", dp_bus.start_dp, 0);
      chk("async_reset_instruction", dp_bus.instruction_dp, 0);
      chk("async_reset_ant_index", ant_index, 0);
      @(negedge clock);
      @(negedge clock);
      expq.delete();
      resetn = 1'b1;
      n0 = n_txn;
      k = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clock);
         if (dp_bus.start_dp === 1'b1) k++;
      end
      chk("post_reset_no_request", k, 0);
      chk("post_reset_no_txn", n_txn - n0, 0);
      chk("post_reset_finished", finished, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
